// File: rtl/lc3_control_fsm_pkg.sv
// Shared opcode/ALU encodings, FSM state and instruction-class types for the
// LC-3 multi-cycle control unit.
package lc3_pkg;

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_EXT = 4'b1011;
  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0011;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_AND = 4'b0001;
  localparam logic [3:0] ALU_NOT = 4'b0100;
  localparam logic [3:0] ALU_MUL = 4'b0101;
  localparam logic [3:0] ALU_SL  = 4'b0110;
  localparam logic [3:0] ALU_SR  = 4'b0111;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_BRANCH = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } lc3_state_e;

  typedef enum logic [2:0] {
    CLS_ALU = 3'd0,
    CLS_BR  = 3'd1,
    CLS_JMP = 3'd2,
    CLS_LD  = 3'd3,
    CLS_ST  = 3'd4,
    CLS_ILL = 3'd5
  } inst_class_e;

  // BR is taken when any condition bit selected in IR[11:9] matches a live flag.
  function automatic logic br_taken(input logic [2:0] nzp, input logic n,
                                    input logic z, input logic p);
    return |(nzp & {n, z, p});
  endfunction

endpackage

// File: rtl/lc3_control_fsm_if.sv
// Memory port, condition-code inputs and datapath control outputs of the
// LC-3 control unit.
interface lc3_control_fsm_if #(
  parameter int WIDTH      = 16,
  parameter int ALU_CTRL_W = 4
);
  // Handshake: MEM_REQ stays high until a cycle in which MEM_READY is also
  // high; that cycle completes the transfer (read data sampled, store done).
  logic [WIDTH-1:0]      MEM_RDATA;
  logic                  MEM_READY;
  logic                  FLAG_N;
  logic                  FLAG_Z;
  logic                  FLAG_P;
  logic                  MEM_REQ;
  logic                  MEM_WE;
  logic                  MEM_ADDR_SEL;
  logic [ALU_CTRL_W-1:0] ALU_CONTROL;
  logic                  IS_IMMEDIATE;
  logic [WIDTH-1:0]      IMM;
  logic [2:0]            DR;
  logic [2:0]            SR1;
  logic [2:0]            SR2;
  logic                  REG_WE;
  logic                  WB_SEL;
  logic                  CC_LOAD;
  logic                  PC_INC;
  logic                  PC_LOAD;
  logic                  PC_SRC;
  logic                  ILLEGAL;

  modport master (
    input  MEM_RDATA, MEM_READY, FLAG_N, FLAG_Z, FLAG_P,
    output MEM_REQ, MEM_WE, MEM_ADDR_SEL, ALU_CONTROL, IS_IMMEDIATE, IMM,
           DR, SR1, SR2, REG_WE, WB_SEL, CC_LOAD, PC_INC, PC_LOAD, PC_SRC,
           ILLEGAL
  );

  modport slave (
    output MEM_RDATA, MEM_READY, FLAG_N, FLAG_Z, FLAG_P,
    input  MEM_REQ, MEM_WE, MEM_ADDR_SEL, ALU_CONTROL, IS_IMMEDIATE, IMM,
           DR, SR1, SR2, REG_WE, WB_SEL, CC_LOAD, PC_INC, PC_LOAD, PC_SRC,
           ILLEGAL
  );
endinterface

// File: rtl/lc3_control_fsm_inst_decode.sv
// Combinational instruction decode: IR -> ALU op, immediate, register
// addresses, instruction class and illegal-opcode indication.
module lc3_inst_decode
  import lc3_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int ALU_CTRL_W = 4,
  parameter bit EXT_ALU_EN = 1'b1
) (
  input  logic [15:0]           ir_i,
  output logic [ALU_CTRL_W-1:0] alu_ctrl_o,
  output logic                  is_imm_o,
  output logic [WIDTH-1:0]      imm_o,
  output logic [2:0]            dr_o,
  output logic [2:0]            sr1_o,
  output logic [2:0]            sr2_o,
  output inst_class_e           cls_o,
  output logic                  illegal_o
);

  logic [3:0]  op;
  logic [3:0]  alu;
  logic        short_imm;

  assign op = ir_i[15:12];

  always_comb begin
    alu      = ALU_ADD;
    cls_o    = CLS_ILL;
    is_imm_o = 1'b0;
    case (op)
      OP_ADD: begin alu = ALU_ADD; cls_o = CLS_ALU; is_imm_o = ir_i[5]; end
      OP_AND: begin alu = ALU_AND; cls_o = CLS_ALU; is_imm_o = ir_i[5]; end
      OP_NOT: begin alu = ALU_NOT; cls_o = CLS_ALU; end
      OP_EXT: begin
        if (EXT_ALU_EN) begin
          case (ir_i[4:3])
            2'b00:   begin alu = ALU_MUL; cls_o = CLS_ALU; end
            2'b10:   begin alu = ALU_SL;  cls_o = CLS_ALU; end
            2'b01:   begin alu = ALU_SR;  cls_o = CLS_ALU; end
            default: cls_o = CLS_ILL;
          endcase
        end
      end
      OP_BR:   cls_o = CLS_BR;
      OP_JMP:  cls_o = CLS_JMP;
      OP_LD:   cls_o = CLS_LD;
      OP_ST:   cls_o = CLS_ST;
      default: cls_o = CLS_ILL;
    endcase
  end

  // imm5 only for the register/immediate ALU forms; everything else uses offset9.
  assign short_imm  = (op == OP_ADD) || (op == OP_AND);
  assign imm_o      = short_imm ? WIDTH'($signed(ir_i[4:0]))
                                : WIDTH'($signed(ir_i[8:0]));
  assign alu_ctrl_o = ALU_CTRL_W'(alu);
  assign dr_o       = ir_i[11:9];
  assign sr1_o      = ir_i[8:6];
  assign sr2_o      = ir_i[2:0];
  assign illegal_o  = (cls_o == CLS_ILL);

endmodule

// File: rtl/lc3_control_fsm.sv
// LC-3 multi-cycle control unit: owns IR and the fetch/decode/execute FSM,
// and drives datapath strobes from state, IR and condition codes.
module lc3_control_fsm
  import lc3_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int ALU_CTRL_W = 4,
  parameter bit EXT_ALU_EN = 1'b1
) (
  input  logic                CLK,
  input  logic                RST_N,
  lc3_control_fsm_if.master   bus,
  output lc3_state_e          dbg_state_o
);

  lc3_state_e       state_q, state_d;
  logic [WIDTH-1:0] ir_q, ir_d;
  logic             illegal_q, illegal_d;

  logic [ALU_CTRL_W-1:0] alu_ctrl;
  logic                  is_imm;
  logic [WIDTH-1:0]      imm;
  logic [2:0]            dr, sr1, sr2;
  inst_class_e           cls;
  logic                  dec_illegal;

  logic mem_req, mem_we, addr_sel, reg_we, wb_sel, cc_load;
  logic pc_inc, pc_load, pc_src;

  lc3_inst_decode #(
    .WIDTH      (WIDTH),
    .ALU_CTRL_W (ALU_CTRL_W),
    .EXT_ALU_EN (EXT_ALU_EN)
  ) u_decode (
    .ir_i       (ir_q[15:0]),
    .alu_ctrl_o (alu_ctrl),
    .is_imm_o   (is_imm),
    .imm_o      (imm),
    .dr_o       (dr),
    .sr1_o      (sr1),
    .sr2_o      (sr2),
    .cls_o      (cls),
    .illegal_o  (dec_illegal)
  );

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    illegal_d = illegal_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    addr_sel  = 1'b0;
    reg_we    = 1'b0;
    wb_sel    = 1'b0;
    cc_load   = 1'b0;
    pc_inc    = 1'b0;
    pc_load   = 1'b0;
    pc_src    = 1'b0;
    case (state_q)
      ST_FETCH: begin
        mem_req = 1'b1;
        if (bus.MEM_READY) begin
          ir_d    = bus.MEM_RDATA;
          pc_inc  = 1'b1;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (dec_illegal) begin
          state_d   = ST_HALT;
          illegal_d = 1'b1;
        end else begin
          case (cls)
            CLS_ALU:         state_d = ST_EXEC;
            CLS_BR, CLS_JMP: state_d = ST_BRANCH;
            default:         state_d = ST_MEM;
          endcase
        end
      end
      ST_EXEC: begin
        reg_we  = 1'b1;
        cc_load = 1'b1;
        state_d = ST_FETCH;
      end
      ST_BRANCH: begin
        if (cls == CLS_JMP) begin
          pc_load = 1'b1;
          pc_src  = 1'b1;
        end else begin
          pc_load = br_taken(ir_q[11:9], bus.FLAG_N, bus.FLAG_Z, bus.FLAG_P);
        end
        state_d = ST_FETCH;
      end
      ST_MEM: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = (cls == CLS_ST);
        if (bus.MEM_READY) begin
          state_d = (cls == CLS_ST) ? ST_FETCH : ST_WB;
        end
      end
      ST_WB: begin
        reg_we  = 1'b1;
        wb_sel  = 1'b1;
        cc_load = 1'b1;
        state_d = ST_FETCH;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= ST_FETCH;
      ir_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      illegal_q <= illegal_d;
    end
  end

  // Reset parks the FSM in FETCH; gating with RST_N keeps the request and
  // PC increment quiet while reset is held, including mid-transfer.
  assign bus.MEM_REQ      = mem_req & RST_N;
  assign bus.PC_INC       = pc_inc & RST_N;
  assign bus.MEM_WE       = mem_we;
  assign bus.MEM_ADDR_SEL = addr_sel;
  assign bus.REG_WE       = reg_we;
  assign bus.WB_SEL       = wb_sel;
  assign bus.CC_LOAD      = cc_load;
  assign bus.PC_LOAD      = pc_load;
  assign bus.PC_SRC       = pc_src;
  assign bus.ALU_CONTROL  = alu_ctrl;
  assign bus.IS_IMMEDIATE = is_imm;
  assign bus.IMM          = imm;
  assign bus.DR           = dr;
  assign bus.SR1          = sr1;
  assign bus.SR2          = sr2;
  assign bus.ILLEGAL      = illegal_q;
  assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_lc3_control_fsm.sv
// Bench for lc3_control_fsm: directed scenarios plus random instruction
// streams checked cycle by cycle against a phase-level reference model.
module tb_lc3_control_fsm;
  import lc3_pkg::*;

  localparam int WIDTH      = 16;
  localparam int ALU_CTRL_W = 4;
  localparam bit EXT_ALU_EN = 1'b1;

  localparam int C_ALU = 0, C_BR = 1, C_JMP = 2, C_LD = 3, C_ST = 4, C_ILL = 5;

  // Observed vector: {ILLEGAL, PC_SRC, WB_SEL, ADDR_SEL, MEM_REQ, MEM_WE,
  //                   PC_INC, REG_WE, CC_LOAD, PC_LOAD}
  localparam logic [9:0] CARE_BASE = 10'h23F;
  localparam logic [9:0] CARE_ADDR = 10'h040;
  localparam logic [9:0] CARE_WB   = 10'h080;
  localparam logic [9:0] CARE_SRC  = 10'h100;

  logic       CLK   = 1'b0;
  logic       RST_N = 1'b1;
  lc3_state_e dbg_state;

  lc3_control_fsm_if #(.WIDTH(WIDTH), .ALU_CTRL_W(ALU_CTRL_W)) bus ();

  lc3_control_fsm #(
    .WIDTH      (WIDTH),
    .ALU_CTRL_W (ALU_CTRL_W),
    .EXT_ALU_EN (EXT_ALU_EN)
  ) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .bus         (bus.master),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 CLK = ~CLK;

  // ---------------- scoreboard ----------------
  int         n_checks = 0;
  int         n_errors = 0;
  logic [9:0] exp_q[$];
  logic [9:0] care_q[$];
  bit         rdy_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] observe();
    return {bus.ILLEGAL, bus.PC_SRC, bus.WB_SEL, bus.MEM_ADDR_SEL, bus.MEM_REQ,
            bus.MEM_WE, bus.PC_INC, bus.REG_WE, bus.CC_LOAD, bus.PC_LOAD};
  endfunction

  function automatic logic [9:0] mk(input bit ill, input bit src, input bit wbs,
                                    input bit asel, input bit req, input bit we,
                                    input bit inc, input bit rwe, input bit cc,
                                    input bit pcl);
    return {ill, src, wbs, asel, req, we, inc, rwe, cc, pcl};
  endfunction

  // ---------------- reference model ----------------
  function automatic int exp_class(input logic [15:0] ins);
    case (ins[15:12])
      4'b0001, 4'b0101, 4'b1001: return C_ALU;
      4'b1011: return (EXT_ALU_EN && ins[4:3] != 2'b11) ? C_ALU : C_ILL;
      4'b0000: return C_BR;
      4'b1100: return C_JMP;
      4'b0010: return C_LD;
      4'b0011: return C_ST;
      default: return C_ILL;
    endcase
  endfunction

  function automatic logic [3:0] exp_alu(input logic [15:0] ins);
    case (ins[15:12])
      4'b0001: return 4'd0;
      4'b0101: return 4'd1;
      4'b1001: return 4'd4;
      4'b1011: return (ins[4:3] == 2'b00) ? 4'd5 : (ins[4:3] == 2'b10) ? 4'd6 : 4'd7;
      default: return 4'd0;
    endcase
  endfunction

  function automatic bit is_addand(input logic [15:0] ins);
    return ins[15:12] == 4'b0001 || ins[15:12] == 4'b0101;
  endfunction

  function automatic logic [15:0] exp_imm(input logic [15:0] ins);
    int v;
    if (is_addand(ins)) begin
      v = int'(ins[4:0]);
      if (v >= 16) v -= 32;
    end else begin
      v = int'(ins[8:0]);
      if (v >= 256) v -= 512;
    end
    return 16'(v);
  endfunction

  // Builds the expected per-cycle trace of one instruction, phase by phase.
  task automatic build_trace(input logic [15:0] ins, input int fw, input int mw,
                             output int cls);
    bit taken;
    cls = exp_class(ins);
    for (int i = 0; i <= fw; i++) begin
      exp_q.push_back(mk(0, 0, 0, 0, 1, 0, i == fw, 0, 0, 0));
      care_q.push_back(CARE_BASE | CARE_ADDR);
      rdy_q.push_back(i == fw);
    end
    exp_q.push_back('0); care_q.push_back(CARE_BASE); rdy_q.push_back(1'($urandom_range(0, 1)));
    case (cls)
      C_ALU: begin
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
        care_q.push_back(CARE_BASE | CARE_WB); rdy_q.push_back(1'($urandom_range(0, 1)));
      end
      C_BR: begin
        taken = (ins[11] & bus.FLAG_N) | (ins[10] & bus.FLAG_Z) | (ins[9] & bus.FLAG_P);
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, taken));
        care_q.push_back(taken ? (CARE_BASE | CARE_SRC) : CARE_BASE);
        rdy_q.push_back(1'($urandom_range(0, 1)));
      end
      C_JMP: begin
        exp_q.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1));
        care_q.push_back(CARE_BASE | CARE_SRC); rdy_q.push_back(1'($urandom_range(0, 1)));
      end
      C_LD, C_ST: begin
        for (int i = 0; i <= mw; i++) begin
          exp_q.push_back(mk(0, 0, 0, 1, 1, cls == C_ST, 0, 0, 0, 0));
          care_q.push_back(CARE_BASE | CARE_ADDR);
          rdy_q.push_back(i == mw);
        end
        if (cls == C_LD) begin
          exp_q.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 1, 0));
          care_q.push_back(CARE_BASE | CARE_WB); rdy_q.push_back(1'($urandom_range(0, 1)));
        end
      end
      default: begin
        for (int i = 0; i < 4; i++) begin
          exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
          care_q.push_back(CARE_BASE); rdy_q.push_back(1'($urandom_range(0, 1)));
        end
      end
    endcase
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    RST_N = 1'b0;
    bus.MEM_READY = 1'b0;
    #1;
    check("rst_strobes", 32'(observe() & CARE_BASE), 32'h0);
    check("rst_alu", 32'(bus.ALU_CONTROL), 32'h0);
    check("rst_imm", 32'(bus.IMM), 32'h0);
    check("rst_regs", 32'({bus.DR, bus.SR1, bus.SR2}), 32'h0);
    repeat (2) @(posedge CLK);
    #1;
    RST_N = 1'b1;
  endtask

  task automatic check_fields(input string name, input logic [15:0] ins, input int cls);
    check({name, "_regs"}, 32'({bus.DR, bus.SR1, bus.SR2}), 32'({ins[11:9], ins[8:6], ins[2:0]}));
    check({name, "_imm"}, 32'(bus.IMM), 32'(exp_imm(ins)));
    check({name, "_isimm"}, 32'(bus.IS_IMMEDIATE), 32'(is_addand(ins) & ins[5]));
    if (cls == C_ALU) check({name, "_alu"}, 32'(bus.ALU_CONTROL), 32'(exp_alu(ins)));
  endtask

  task automatic run_instr(input string name, input logic [15:0] ins, input int fw,
                           input int mw);
    int         cls;
    int         n;
    logic [9:0] e, m;
    build_trace(ins, fw, mw, cls);
    n = exp_q.size();
    for (int c = 0; c < n; c++) begin
      e = exp_q.pop_front();
      m = care_q.pop_front();
      bus.MEM_READY = rdy_q.pop_front();
      bus.MEM_RDATA = (c == fw) ? ins : 16'($urandom);
      @(negedge CLK);
      check($sformatf("%s_cyc%0d", name, c), 32'(observe() & m), 32'(e & m));
      if (c == fw + 1) check_fields(name, ins, cls);
      if (cls == C_ILL && c > fw + 1) check({name, "_halt"}, 32'(dbg_state), 32'(ST_HALT));
      @(posedge CLK);
      #1;
    end
    bus.MEM_READY = 1'b0;
    if (cls == C_ILL) do_reset();
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0]  legal_ops [8];
    logic [3:0]  bad_ops [8];
    logic [15:0] ins;
    legal_ops = '{4'b0001, 4'b0101, 4'b1001, 4'b1011, 4'b0000, 4'b1100, 4'b0010, 4'b0011};
    bad_ops   = '{4'b0100, 4'b0110, 4'b0111, 4'b1000, 4'b1010, 4'b1101, 4'b1110, 4'b1111};
    bus.MEM_READY = 1'b0;
    bus.MEM_RDATA = '0;
    {bus.FLAG_N, bus.FLAG_Z, bus.FLAG_P} = 3'b000;
    #2;
    do_reset();

    run_instr("add", 16'h1283, 0, 0);
    run_instr("and_imm", 16'h527F, 0, 0);
    run_instr("ld_wait", 16'h2205, 0, 3);
    {bus.FLAG_N, bus.FLAG_Z, bus.FLAG_P} = 3'b010;
    run_instr("br_z", 16'h0A02, 0, 0);
    {bus.FLAG_N, bus.FLAG_Z, bus.FLAG_P} = 3'b001;
    run_instr("br_p", 16'h0A02, 1, 0);
    run_instr("jmp", 16'hC1C0, 0, 0);
    run_instr("st", 16'h3A10, 2, 1);
    run_instr("ext_mul", 16'hB280, 0, 0);
    run_instr("ext_bad", 16'hB298, 0, 0);

    // Reset pulsed while a fetch is waiting on memory.
    run_instr("add_pre", 16'h1283, 0, 0);
    bus.MEM_READY = 1'b0;
    @(negedge CLK);
    check("midrst_req_before", 32'(bus.MEM_REQ), 32'h1);
    #2;
    RST_N = 1'b0;
    #1;
    check("midrst_req_async", 32'(bus.MEM_REQ), 32'h0);
    check("midrst_regs", 32'({bus.DR, bus.SR1, bus.SR2}), 32'h0);
    bus.MEM_READY = 1'b1;
    bus.MEM_RDATA = 16'h1283;
    @(posedge CLK);
    #1;
    check("midrst_pcinc", 32'(bus.PC_INC), 32'h0);
    check("midrst_ir_hold", 32'({bus.DR, bus.SR1, bus.SR2}), 32'h0);
    bus.MEM_READY = 1'b0;
    RST_N = 1'b1;
    run_instr("nop_restart", 16'h0000, 1, 0);

    for (int i = 0; i < 200; i++) begin
      ins = 16'($urandom);
      ins[15:12] = ($urandom_range(0, 9) == 0) ? bad_ops[$urandom_range(0, 7)]
                                               : legal_ops[$urandom_range(0, 7)];
      {bus.FLAG_N, bus.FLAG_Z, bus.FLAG_P} = 3'($urandom_range(0, 7));
      run_instr($sformatf("rnd%0d", i), ins, $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
